// File: rtl/seq_signed_divmod.sv
// Multi-cycle signed divide/modulo unit with truncated or floored rounding.
// The magnitudes go through a radix-2 restoring divider, one quotient bit per
// cycle, MSB first. A single FIXUP cycle then applies the signs and the
// rounding mode.
module seq_signed_divmod #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_floored,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [WIDTH-1:0] out_rem,
    output logic             out_div_zero,
    output logic             out_overflow
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg, b_reg, b_mag;
    logic [WIDTH-1:0] aq;        // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH:0]   prem;      // partial remainder; the extra bit holds the trial sign
    logic             sa, sb, floored;

    logic [WIDTH:0]   prem_shift, diff;
    logic [WIDTH-1:0] q_t, r_t, fix_q, fix_r;
    logic             adjust;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = (in_b == '0) ? FIXUP : CALC;
            end
            CALC:    if (cnt == CW'(WIDTH - 1)) state_next = FIXUP;
            FIXUP:   state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Trial subtract for one restoring step, plus the sign/rounding fixup
    always_comb begin
        prem_shift = {prem[WIDTH-1:0], aq[WIDTH-1]};
        diff       = prem_shift - {1'b0, b_mag};
        q_t        = (sa ^ sb) ? -aq : aq;
        r_t        = sa ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
        // Floored mode: a nonzero remainder must take the divisor's sign
        adjust     = floored && (r_t != '0) && (sa != sb);
        fix_q      = adjust ? q_t - WIDTH'(1) : q_t;
        fix_r      = adjust ? r_t + b_reg : r_t;
    end

    // Datapath: latch operands, iterate, fix up the signs, hold the result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt          <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            b_mag        <= '0;
            aq           <= '0;
            prem         <= '0;
            sa           <= 1'b0;
            sb           <= 1'b0;
            floored      <= 1'b0;
            out_quot     <= '0;
            out_rem      <= '0;
            out_div_zero <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_reg        <= in_a;
                    b_reg        <= in_b;
                    sa           <= in_a[WIDTH-1];
                    sb           <= in_b[WIDTH-1];
                    floored      <= in_floored;
                    // |-2^(W-1)| = 2^(W-1) still fits as an unsigned W-bit value
                    aq           <= in_a[WIDTH-1] ? -in_a : in_a;
                    b_mag        <= in_b[WIDTH-1] ? -in_b : in_b;
                    prem         <= '0;
                    cnt          <= '0;
                    out_div_zero <= (in_b == '0);
                    out_overflow <= (in_a == {1'b1, {(WIDTH-1){1'b0}}}) && (in_b == '1);
                end
                CALC: begin
                    cnt  <= cnt + CW'(1);
                    aq   <= {aq[WIDTH-2:0], ~diff[WIDTH]};
                    prem <= diff[WIDTH] ? prem_shift : diff;
                end
                FIXUP: begin
                    if (out_div_zero) begin
                        out_quot <= '1;
                        out_rem  <= a_reg;
                    end else begin
                        out_quot <= fix_q;
                        out_rem  <= fix_r;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_signed_divmod.sv
// Directed bench for seq_signed_divmod (WIDTH=11): hand vectors, a sweep
// against a behavioural model, a back-pressure hold and a reset mid-CALC.
module tb_seq_signed_divmod;
    localparam int W = 11;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_floored, out_ready;
    logic         in_ready, out_valid, out_div_zero, out_overflow;
    logic [W-1:0] in_a, in_b, out_quot, out_rem;

    int checks = 0;
    int errors = 0;

    seq_signed_divmod #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_floored(in_floored),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quot(out_quot), .out_rem(out_rem),
        .out_div_zero(out_div_zero), .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Integer semantics: '/' and '%' truncate; floored moves rem to b's sign
    task automatic model(input int a, input int b, input bit fl,
                         output int q, output int r);
        if (b == 0) begin
            q = -1; r = a;
        end else begin
            q = a / b; r = a % b;
            if (fl && r != 0 && ((r < 0) != (b < 0))) begin
                q = q - 1; r = r + b;
            end
        end
    endtask

    // One operation: issue, bounded wait for out_valid, check, optional hold, handshake
    task automatic do_op(input string tag, input int a, input int b, input bit fl,
                         input int eq, input int er, input bit edz, input bit eov,
                         input int elat, input int hold);
        int n;
        logic [W-1:0] xq, xr;
        xq = eq[W-1:0];
        xr = er[W-1:0];
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_a = a[W-1:0]; in_b = b[W-1:0]; in_floored = fl; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_floored = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(elat));
        chk({tag, " quot"}, 32'(out_quot), 32'(xq));
        chk({tag, " rem"}, 32'(out_rem), 32'(xr));
        chk({tag, " flags"}, {30'd0, out_div_zero, out_overflow}, {30'd0, edz, eov});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, " hold"}, {out_valid, in_ready, out_quot, out_rem},
                {1'b1, 1'b0, xq, xr});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " back to idle"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        int q, r;
        bit seen;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_floored = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset hs", {30'd0, in_ready, out_valid}, 32'd2);
        chk("reset quot/rem", {10'd0, out_quot, out_rem}, 32'd0);
        chk("reset flags", {30'd0, out_div_zero, out_overflow}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("-50/7 t",   -50,  7, 1'b0,   -7, -1, 1'b0, 1'b0, 13, 0);
        do_op("-50/7 f",   -50,  7, 1'b1,   -8,  6, 1'b0, 1'b0, 13, 0);
        do_op("5/-3 t",      5, -3, 1'b0,   -1,  2, 1'b0, 1'b0, 13, 0);
        do_op("5/-3 f",      5, -3, 1'b1,   -2, -1, 1'b0, 1'b0, 13, 0);
        do_op("-5/-3 t",    -5, -3, 1'b0,    1, -2, 1'b0, 1'b0, 13, 0);
        do_op("-5/-3 f",    -5, -3, 1'b1,    1, -2, 1'b0, 1'b0, 13, 0);
        do_op("5/3 t",       5,  3, 1'b0,    1,  2, 1'b0, 1'b0, 13, 0);
        do_op("5/3 f",       5,  3, 1'b1,    1,  2, 1'b0, 1'b0, 13, 0);
        do_op("ovf t",   -1024, -1, 1'b0, -1024, 0, 1'b0, 1'b1, 13, 0);
        do_op("ovf f",   -1024, -1, 1'b1, -1024, 0, 1'b0, 1'b1, 13, 0);
        do_op("1023/-1024 f", 1023, -1024, 1'b1, -1, -1, 1'b0, 1'b0, 13, 0);
        do_op("stall",     -50,  7, 1'b1,   -8,  6, 1'b0, 1'b0, 13, 20);

        for (int a = -50; a <= 49; a++) begin
            for (int m = 0; m < 2; m++) begin
                model(a, 7, m[0], q, r);
                do_op("sweep", a, 7, m[0], q, r, 1'b0, 1'b0, 13, 0);
            end
        end

        do_op("17/0 t",     17,  0, 1'b0,   -1, 17, 1'b1, 1'b0, 2, 0);
        do_op("-9/0 f",     -9,  0, 1'b1,   -1, -9, 1'b1, 1'b0, 2, 0);

        // Reset in the middle of CALC drops the operation
        in_a = 11'd100; in_b = 11'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midreset hs", {30'd0, in_ready, out_valid}, 32'd2);
        chk("midreset regs", {8'd0, out_quot, out_rem, out_div_zero, out_overflow}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        chk("dropped op silent", 32'(seen), 32'd0);
        do_op("after reset", 100, 3, 1'b0, 33, 1, 1'b0, 1'b0, 13, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
